// File: rtl/clk_gate_ctrl.sv
// rtl/clk_gate_ctrl.sv - APB low-power clock gate sequencer; optional auto-wake timer via CLK_GATE_AUTO_WAKE_EN
module clk_gate_ctrl #(
    parameter int                 CNT_W   = 8,
    parameter logic [CNT_W-1:0]   DLY_RST = 8'h10
) (
    input  logic        i_pad_clk,
    input  logic        clkrst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [3:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    input  logic        cpu_lp_req,
    input  logic        wake_irq,
    output logic        lp_ack,
    output logic        gate_en0,
    output logic        gate_en1
);

    typedef enum logic [2:0] {
        ST_RUN   = 3'd0,
        ST_ENTER = 3'd1,
        ST_GATED = 3'd2,
        ST_EXIT  = 3'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] dly;
    logic             lp_en, mode, mode_q, mode_n;
    logic [7:0]       wcnt;
    logic             wcnt_inc;
    logic             wr_en, rd_setup, stat_wr;
    logic [1:0]       addr;
    logic [31:0]      rd_mux;
    logic             unused_bits;

`ifdef CLK_GATE_AUTO_WAKE_EN
    logic [15:0] tmo, tmr;
    logic        tmo_flag, tmo_set, tmo_hit;
    // Timer hits when its decrement lands on zero, so GATED lasts exactly TMO cycles
    assign tmo_hit = (state == ST_GATED) && (tmr == 16'd1);
`else
    logic tmo_flag;
    assign tmo_flag = 1'b0;
`endif

    assign addr        = paddr[3:2];
    assign wr_en       = psel & penable & pwrite;
    assign rd_setup    = psel & ~penable & ~pwrite;
    assign stat_wr     = wr_en && (addr == 2'd2);
    assign unused_bits = ^{paddr[1:0], pwdata[31:CNT_W]};

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        mode_n   = mode_q;
        wcnt_inc = 1'b0;
`ifdef CLK_GATE_AUTO_WAKE_EN
        tmo_set  = 1'b0;
`endif
        case (state)
            ST_RUN: begin
                if (lp_en && cpu_lp_req && !wake_irq) begin
                    state_n = ST_ENTER;
                    cnt_n   = dly;
                    mode_n  = mode;
                end
            end
            ST_ENTER: begin
                if (wake_irq || !cpu_lp_req) begin
                    state_n  = ST_RUN;
                    wcnt_inc = 1'b1;
                end else if (cnt == '0) begin
                    state_n = ST_GATED;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            ST_GATED: begin
                if (wake_irq || !cpu_lp_req) begin
                    state_n  = ST_EXIT;
                    cnt_n    = dly;
                    wcnt_inc = wake_irq;
                end
`ifdef CLK_GATE_AUTO_WAKE_EN
                else if (tmo_hit) begin
                    state_n = ST_EXIT;
                    cnt_n   = dly;
                    tmo_set = 1'b1;
                end
`endif
            end
            ST_EXIT: begin
                if (cnt == '0) begin
                    state_n = ST_RUN;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            default: state_n = ST_RUN;
        endcase
    end

    always_comb begin
        rd_mux = 32'd0;
        case (addr)
            2'd0: rd_mux = {30'd0, mode, lp_en};
            2'd1: rd_mux = {{(32-CNT_W){1'b0}}, dly};
            2'd2: rd_mux = {15'd0, tmo_flag, wcnt, 5'd0, state};
`ifdef CLK_GATE_AUTO_WAKE_EN
            2'd3: rd_mux = {16'd0, tmo};
`endif
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge i_pad_clk) begin
        if (clkrst) begin
            state    <= ST_RUN;
            cnt      <= '0;
            mode_q   <= 1'b0;
            lp_en    <= 1'b0;
            mode     <= 1'b0;
            dly      <= DLY_RST;
            wcnt     <= 8'd0;
            prdata   <= 32'd0;
            lp_ack   <= 1'b0;
            gate_en0 <= 1'b0;
            gate_en1 <= 1'b0;
`ifdef CLK_GATE_AUTO_WAKE_EN
            tmo      <= 16'd0;
            tmr      <= 16'd0;
            tmo_flag <= 1'b0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            mode_q <= mode_n;
            // Outputs follow the next state so they align exactly with GATED residency
            lp_ack   <= (state_n == ST_GATED);
            gate_en0 <= (state_n == ST_GATED) && !mode_n;
            gate_en1 <= (state_n == ST_GATED) && mode_n;

            if (wr_en) begin
                case (addr)
                    2'd0: begin
                        lp_en <= pwdata[0];
                        mode  <= pwdata[1];
                    end
                    2'd1: dly <= pwdata[CNT_W-1:0];
`ifdef CLK_GATE_AUTO_WAKE_EN
                    2'd3: tmo <= pwdata[15:0];
`endif
                    default: ;
                endcase
            end

            if (stat_wr) begin
                wcnt <= 8'd0;
            end else if (wcnt_inc && (wcnt != 8'hFF)) begin
                wcnt <= wcnt + 8'd1;
            end

`ifdef CLK_GATE_AUTO_WAKE_EN
            if (state != ST_GATED && state_n == ST_GATED) begin
                tmr <= tmo;
            end else if (state == ST_GATED && tmr != 16'd0) begin
                tmr <= tmr - 16'd1;
            end
            if (stat_wr) begin
                tmo_flag <= 1'b0;
            end else if (tmo_set) begin
                tmo_flag <= 1'b1;
            end
`endif

            if (rd_setup) begin
                prdata <= rd_mux;
            end
        end
    end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Low-power clock sequencer directly upstream of the system clock generator.
- Drives that block's gate_en0 input (select slow divided clock) and gate_en1 input (stop cpu_clk).
- Runs on the ungated pad clock, so it stays alive while cpu_clk is slowed or stopped.
- APB-programmable: enable, mode, settle delay. Sequences entry on a core low-power request and exit on wake interrupt or request drop.

Parameters:
- CNT_W, 8: width of settle counter and DLY register.
- DLY_RST, 8'h10: reset value of DLY.

Ports:
- i_pad_clk  input  1  free-running pad clock; all logic on rising edge.
- clkrst  input  1  synchronous active-high reset.
- psel  input  1  APB select.
- penable  input  1  APB enable.
- pwrite  input  1  APB write.
- paddr  input  4  APB byte offset; bits [1:0] ignored.
- pwdata  input  32  APB write data.
- prdata  output  32  APB read data, registered.
- cpu_lp_req  input  1  level; core requests low power (WFI).
- wake_irq  input  1  level; pending interrupt/wake source.
- lp_ack  output  1  high while clock is gated.
- gate_en0  output  1  slow-clock select to clock generator.
- gate_en1  output  1  clock-stop to clock generator.

Behaviour:
- Interface: one clock i_pad_clk; reset clkrst is synchronous and active-high.
- Reset values: gate_en0=0, gate_en1=0, lp_ack=0, prdata=0; state=RUN; CTRL=0; DLY=DLY_RST; WCNT=0; cnt=0.
- Registers:
  - 0x0 CTRL: [0] lp_en, [1] mode (0=slow, 1=stop).
  - 0x4 DLY: [CNT_W-1:0].
  - 0x8 STAT: [2:0] state code, [15:8] WCNT, read-only. Any write clears WCNT.
  - 0xC: see Optional Feature.
  - Unmapped offsets read 0; writes ignored.
- APB write: commits at edge where psel&penable&pwrite; no wait states.
- APB read: prdata loaded at setup edge (psel&!penable&!pwrite); valid during access phase; holds value otherwise.
- State codes: RUN=0, ENTER=1, GATED=2, EXIT=3.
- RUN:
  - lp_en & cpu_lp_req & !wake_irq -> ENTER.
  - On that edge: cnt<=DLY; mode latched to mode_q.
- ENTER:
  - wake_irq or !cpu_lp_req -> RUN (abort); WCNT+1, saturating at 8'hFF. Abort has priority over cnt==0.
  - Else cnt==0 -> GATED; else cnt-1.
- GATED:
  - lp_ack=1; gate_en0 = !mode_q, gate_en1 = mode_q.
  - All three outputs registered: assert first cycle in GATED, drop the cycle state leaves GATED.
  - wake_irq or !cpu_lp_req -> EXIT, cnt<=DLY. A wake_irq exit increments WCNT (saturating).
- EXIT:
  - All gate outputs 0; cnt==0 -> RUN; else cnt-1.
  - cpu_lp_req ignored until RUN is reached.
- gate_en0 and gate_en1 are never both 1 (mutual-exclusion assertion in bench).
- DLY=0: ENTER and EXIT each last exactly one cycle.
- CTRL writes outside RUN: no effect on current sequence (mode_q held); apply to next entry.
- lp_en cleared while GATED: no forced exit; exit only via wake/request drop.
- Reset in any state: returns to RUN with outputs 0 on the next edge.
- Simultaneous APB write to STAT and a WCNT increment: clear wins.

Optional Feature:
- Macro: CLK_GATE_AUTO_WAKE_EN.
- Defined:
  - 0xC TMO register, 16 bits, reset 0.
  - 16-bit timer loads TMO on entry to GATED and decrements each cycle.
  - TMO!=0 and timer reaches 0 in GATED -> EXIT (no WCNT increment); STAT[16] tmo_flag set, cleared by any write to STAT.
  - TMO=0: timer disabled.
- Undefined: 0xC reads 0, writes ignored, STAT[16]=0, no timer logic.

Test Plan:
- Reset: drive clkrst 2 cycles, read 0x0/0x4/0x8 -> 0, 0x10, 0; gate_en0/gate_en1/lp_ack = 0.
- Slow entry/exit: CTRL=1, DLY=3, cpu_lp_req=1. Then gate_en0=1 and lp_ack=1 on the 5th edge after request sampled (1 RUN->ENTER, 4 ENTER cycles). Drop request -> gate_en0=0 next edge; RUN after 4 EXIT cycles; STAT WCNT=0.
- Stop mode with wake: CTRL=3, DLY=0, request held. gate_en1=1 with gate_en0=0. Pulse wake_irq -> gate_en1=0 next edge; STAT[15:8]=1.
- Abort: DLY=8; wake_irq asserted 2 cycles into ENTER -> back to RUN, no gate output ever asserted, WCNT=1. 256 aborts -> WCNT saturates at 0xFF; write to 0x8 -> WCNT=0.
- Mode change mid-gate: in GATED slow, write CTRL=3 -> gate_en0 stays 1, gate_en1 stays 0. Next entry uses stop mode.
- CLK_GATE_AUTO_WAKE_EN: TMO=20, DLY=0, request held, no wake -> leaves GATED after 20 cycles; STAT[16]=1, WCNT unchanged.
